// File: rtl/case_conv_arbiter.sv
// Round-robin arbiter sharing one ASCII upper-case converter between NUM_REQ byte streams.
// Optional `STRING_TERM_EN: once a requester wins with a non-NUL byte it owns the output until it sends 8'h00.
module case_conv_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic [1:0]             out_src,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       conv_count
);

    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic [1:0]       r_out_src;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_conv_count;

    logic [3:0]       w_valid_ext;
    logic [7:0]       w_bytes [4];
    logic [2:0]       w_cand;
    logic             w_rr_found;
    logic [1:0]       w_rr_grant;
    logic             w_found;
    logic [1:0]       w_grant;
    logic             w_space;
    logic             w_xfer;
    logic [7:0]       w_sel_data;
    logic [7:0]       w_conv;
    logic [3:0]       w_ready_ext;

    function automatic logic [7:0] f_conv(input logic [7:0] d);
        return (d >= 8'd97 && d <= 8'd122) ? (d & 8'hDF) : d;
    endfunction

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        w_valid_ext = 4'(req_valid);
        for (int i = 0; i < 4; i++) w_bytes[i] = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) w_bytes[i] = req_data[8*i +: 8];

        w_cand     = 3'd0;
        w_rr_found = 1'b0;
        w_rr_grant = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_last} + 3'(k);
            if (w_cand >= 3'(NUM_REQ)) w_cand = w_cand - 3'(NUM_REQ);
            if (!w_rr_found && w_valid_ext[w_cand[1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_grant = w_cand[1:0];
            end
        end
    end

`ifdef STRING_TERM_EN
    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_owner, w_owner_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_found     = w_rr_found;
        w_grant     = w_rr_grant;
        case (r_state)
            S_IDLE: begin
                if (w_xfer && w_sel_data != 8'h00) begin
                    w_state_nxt = S_LOCKED;
                    w_owner_nxt = w_grant;
                end
            end
            S_LOCKED: begin
                w_found = w_valid_ext[r_owner];
                w_grant = r_owner;
                if (w_xfer && w_sel_data == 8'h00) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
`else
    always_comb begin
        w_found = w_rr_found;
        w_grant = w_rr_grant;
    end
`endif

    // Grants are masked while reset is held so no requester sees an accept during reset.
    always_comb begin
        w_space     = rst_n & (~r_out_valid | out_ready);
        w_xfer      = w_found & w_space;
        w_sel_data  = w_bytes[w_grant];
        w_conv      = f_conv(w_sel_data);
        w_ready_ext = 4'd0;
        if (w_xfer) w_ready_ext[w_grant] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= 8'h00;
            r_out_src    <= 2'd0;
            r_last       <= 2'(NUM_REQ - 1);
            r_conv_count <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_conv;
                r_out_src   <= w_grant;
                r_last      <= w_grant;
                if (w_conv != w_sel_data && r_conv_count != '1)
                    r_conv_count <= r_conv_count + CNT_W'(1);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign req_ready  = w_ready_ext[NUM_REQ-1:0];
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_src    = r_out_src;
    assign conv_count = r_conv_count;

endmodule

// File: tb/tb_case_conv_arbiter.sv
// Directed, table-driven bench for case_conv_arbiter; a second instance with CNT_W=2 shares the stimulus
// to exercise counter saturation.
module tb_case_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic        out_ready;

    logic [1:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic [15:0] conv_count;

    logic [1:0]  s_req_ready;
    logic        s_out_valid;
    logic [7:0]  s_out_data;
    logic [1:0]  s_out_src;
    logic [1:0]  s_conv_count;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0] v;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ordy;
        logic [1:0] exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_od;
        logic [1:0] exp_src;
    } vec_t;

    vec_t  vecs[$];
    string tag;

    always #5 clk = ~clk;

    case_conv_arbiter #(.NUM_REQ(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready), .conv_count(conv_count)
    );

    case_conv_arbiter #(.NUM_REQ(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(s_req_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_src(s_out_src), .out_ready(out_ready), .conv_count(s_conv_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic ordy, input logic [1:0] rdy, input logic ov,
                       input logic [7:0] od, input logic [1:0] src);
        vec_t e;
        e.v = v; e.d0 = d0; e.d1 = d1; e.ordy = ordy;
        e.exp_rdy = rdy; e.exp_ov = ov; e.exp_od = od; e.exp_src = src;
        vecs.push_back(e);
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            @(negedge clk);
            req_valid = vecs[i].v;
            req_data  = {vecs[i].d1, vecs[i].d0};
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("%s[%0d].req_ready", tag, i), 32'(req_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d].out_valid", tag, i), 32'(out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("%s[%0d].out_data", tag, i), 32'(out_data), 32'(vecs[i].exp_od));
            check($sformatf("%s[%0d].out_src", tag, i), 32'(out_src), 32'(vecs[i].exp_src));
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held with both requesters valid
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_data  = {8'h62, 8'h61};
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.req_ready", 32'(req_ready), 32'd0);
        check("reset.conv_count", 32'(conv_count), 32'd0);
        check("reset.out_data", 32'(out_data), 32'd0);
        check("reset.out_src", 32'(out_src), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        out_ready = 1'b1;

        // Conversion sweep, requester 0 only
        tag = "sweep";
        add(2'b01, 8'd40,  8'h00, 1'b1, 2'b01, 1'b1, 8'd40,  2'd0);
        add(2'b01, 8'd72,  8'h00, 1'b1, 2'b01, 1'b1, 8'd72,  2'd0);
        add(2'b01, 8'd97,  8'h00, 1'b1, 2'b01, 1'b1, 8'd65,  2'd0);
        add(2'b01, 8'd122, 8'h00, 1'b1, 2'b01, 1'b1, 8'd90,  2'd0);
        add(2'b01, 8'd123, 8'h00, 1'b1, 2'b01, 1'b1, 8'd123, 2'd0);
        add(2'b01, 8'd183, 8'h00, 1'b1, 2'b01, 1'b1, 8'd183, 2'd0);
        add(2'b01, 8'd127, 8'h00, 1'b1, 2'b01, 1'b1, 8'd127, 2'd0);
        add(2'b00, 8'h00,  8'h00, 1'b1, 2'b00, 1'b0, 8'd127, 2'd0);
        run_table();
        check("sweep.conv_count", 32'(conv_count), 32'd2);
        check("sweep.sat_count", 32'(s_conv_count), 32'd2);

        // Round-robin from reset: requester 0 first, then alternate
        do_reset();
        tag = "rr";
        add(2'b11, 8'h61, 8'h78, 1'b1, 2'b01, 1'b1, 8'h41, 2'd0);
        add(2'b11, 8'h62, 8'h78, 1'b1, 2'b10, 1'b1, 8'h58, 2'd1);
        add(2'b11, 8'h62, 8'h79, 1'b1, 2'b01, 1'b1, 8'h42, 2'd0);
        add(2'b10, 8'h62, 8'h79, 1'b1, 2'b10, 1'b1, 8'h59, 2'd1);
        add(2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h59, 2'd1);
        run_table();

        // Backpressure: output held for 5 cycles, then handoff with no bubble
        tag = "bp";
        add(2'b01, 8'h6D, 8'h00, 1'b1, 2'b01, 1'b1, 8'h4D, 2'd0);
        for (int i = 0; i < 5; i++)
            add(2'b01, 8'h6E, 8'h00, 1'b0, 2'b00, 1'b1, 8'h4D, 2'd0);
        add(2'b01, 8'h6E, 8'h00, 1'b1, 2'b01, 1'b1, 8'h4E, 2'd0);
        add(2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h4E, 2'd0);
        run_table();
        check("rr_bp.conv_count", 32'(conv_count), 32'd6);

        // Reset asserted while a byte sits in the output register
        @(negedge clk);
        req_valid = 2'b01;
        req_data  = {8'h00, 8'h71};
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("midrst.pre_valid", 32'(out_valid), 32'd1);
        check("midrst.pre_data", 32'(out_data), 32'h51);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.out_data", 32'(out_data), 32'd0);
        check("midrst.conv_count", 32'(conv_count), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b11;
        req_data  = {8'h6F, 8'h68};
        out_ready = 1'b1;
        #1;
        check("midrst.req_ready", 32'(req_ready), 32'b01);
        @(posedge clk);
        #1;
        check("midrst.out_data_after", 32'(out_data), 32'h48);
        check("midrst.out_src_after", 32'(out_src), 32'd0);

        // Saturation: five lowercase bytes into a 2-bit counter
        do_reset();
        tag = "sat";
        add(2'b01, 8'h61, 8'h00, 1'b1, 2'b01, 1'b1, 8'h41, 2'd0);
        add(2'b01, 8'h62, 8'h00, 1'b1, 2'b01, 1'b1, 8'h42, 2'd0);
        add(2'b01, 8'h63, 8'h00, 1'b1, 2'b01, 1'b1, 8'h43, 2'd0);
        add(2'b01, 8'h64, 8'h00, 1'b1, 2'b01, 1'b1, 8'h44, 2'd0);
        add(2'b01, 8'h65, 8'h00, 1'b1, 2'b01, 1'b1, 8'h45, 2'd0);
        add(2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h45, 2'd0);
        run_table();
        check("sat.sat_count", 32'(s_conv_count), 32'd3);
        check("sat.full_count", 32'(conv_count), 32'd5);

`ifdef STRING_TERM_EN
        // Strings are not interleaved: "hi\0" from src0, then "ok\0" from src1
        do_reset();
        tag = "str";
        add(2'b11, 8'h68, 8'h6F, 1'b1, 2'b01, 1'b1, 8'h48, 2'd0);
        add(2'b11, 8'h69, 8'h6F, 1'b1, 2'b01, 1'b1, 8'h49, 2'd0);
        add(2'b11, 8'h00, 8'h6F, 1'b1, 2'b01, 1'b1, 8'h00, 2'd0);
        add(2'b10, 8'h00, 8'h6F, 1'b1, 2'b10, 1'b1, 8'h4F, 2'd1);
        add(2'b10, 8'h00, 8'h6B, 1'b1, 2'b10, 1'b1, 8'h4B, 2'd1);
        add(2'b10, 8'h00, 8'h00, 1'b1, 2'b10, 1'b1, 8'h00, 2'd1);
        add(2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 2'd1);
        run_table();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
